// File: rtl/ralu_pkg.sv
// Shared encodings for the register-ALU datapath: B micro-op codes, FSM states,
// flag bit positions and common ALU function-select triplets.
package ralu_pkg;

  typedef enum logic [2:0] {
    B_HOLD = 3'b000,
    B_SHL  = 3'b001,
    B_SHR  = 3'b010,
    B_ROL  = 3'b011,
    B_ROR  = 3'b100,
    B_SAR  = 3'b101,
    B_LOAD = 3'b110,
    B_RSVD = 3'b111
  } b_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EXEC
  } state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       p_in;
  } alu_cfg_t;

  localparam alu_cfg_t ALU_ADD    = '{s: 4'b1001, m: 1'b0, p_in: 1'b0};
  localparam alu_cfg_t ALU_SUB    = '{s: 4'b0110, m: 1'b0, p_in: 1'b1};
  localparam alu_cfg_t ALU_PASS_A = '{s: 4'b1111, m: 1'b1, p_in: 1'b0};
  localparam alu_cfg_t ALU_XOR    = '{s: 4'b0110, m: 1'b1, p_in: 1'b0};

  function automatic logic is_shift(b_op_e op);
    return op inside {B_SHL, B_SHR, B_ROL, B_ROR, B_SAR};
  endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational W-bit ALU core with the classic 4-bit S/M/carry-in function set;
// p_out is the active-high carry of the arithmetic sum.
module param_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             p_in,
  output logic [WIDTH-1:0] r,
  output logic             p_out,
  output logic             ovf
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;

  // Every function is x + y + p_in in arithmetic mode and ~(x ^ y) in logic mode.
  always_comb begin
    x     = a | ({WIDTH{s[0]}} & b) | ({WIDTH{s[1]}} & ~b);
    y     = ({WIDTH{s[3]}} & a & b) | ({WIDTH{s[2]}} & a & ~b);
    sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, p_in};
    r     = m ? ~(x ^ y) : sum[WIDTH-1:0];
    p_out = sum[WIDTH];
    ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/ralu_param.sv
// Parametrised register-ALU datapath: GPR file, operand registers A/B with a
// bit-serial B shifter, ALU core, registered flags and a valid/ready micro-op FSM.
module ralu_param
  import ralu_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int N_REGS = 8,
  localparam int AW     = $clog2(N_REGS),
  localparam int SW     = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             p_in,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             ld_a,
  input  logic             a_src,
  input  logic [2:0]       b_op,
  input  logic [SW-1:0]    sh_cnt,
  input  logic             isl,
  input  logic             isr,
  input  logic             wr,
  input  logic             wr_sel,
  input  logic [AW-1:0]    adr_a,
  input  logic [AW-1:0]    adr_b,
  input  logic [AW-1:0]    adr_w,
  output logic [WIDTH-1:0] r,
  output logic             p_out,
  output logic             osl,
  output logic             osr,
  output logic [3:0]       flags,
  output logic             done
);

  state_e           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] gpr [N_REGS];
  logic [SW-1:0]    cnt;
  b_op_e            op_q;
  logic             isl_q, isr_q, wr_q, wr_sel_q;
  logic [AW-1:0]    adr_w_q;
  logic             ovf;

  b_op_e            b_op_in, sh_op;
  logic             accept, sh_isl, sh_isr;
  logic [WIDTH-1:0] sh_b;
  logic             sh_osl, sh_osr;

  assign b_op_in  = b_op_e'(b_op);
  assign op_ready = (state == IDLE);
  assign accept   = op_ready && op_valid;

  param_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .s    (s),
    .m    (m),
    .p_in (p_in),
    .r    (r),
    .p_out(p_out),
    .ovf  (ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (op_valid) next_state = (is_shift(b_op_in) && sh_cnt != '0) ? SHIFT : EXEC;
      SHIFT:   if (cnt == SW'(1)) next_state = EXEC;
      EXEC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The first shift step happens on the accept edge, so it uses the live fields.
  always_comb begin
    sh_op  = accept ? b_op_in : op_q;
    sh_isl = accept ? isl : isl_q;
    sh_isr = accept ? isr : isr_q;
    sh_b   = b_reg;
    sh_osl = osl;
    sh_osr = osr;
    case (sh_op)
      B_SHL: begin sh_b = {b_reg[WIDTH-2:0], sh_isl};       sh_osl = b_reg[WIDTH-1]; end
      B_SHR: begin sh_b = {sh_isr, b_reg[WIDTH-1:1]};       sh_osr = b_reg[0];       end
      B_ROL: begin sh_b = {b_reg[WIDTH-2:0], b_reg[WIDTH-1]}; sh_osl = b_reg[WIDTH-1]; end
      B_ROR: begin sh_b = {b_reg[0], b_reg[WIDTH-1:1]};     sh_osr = b_reg[0];       end
      B_SAR: begin sh_b = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]}; sh_osr = b_reg[0];     end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      osl      <= 1'b0;
      osr      <= 1'b0;
      flags    <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      op_q     <= B_HOLD;
      isl_q    <= 1'b0;
      isr_q    <= 1'b0;
      wr_q     <= 1'b0;
      wr_sel_q <= 1'b0;
      adr_w_q  <= '0;
      for (int unsigned i = 0; i < unsigned'(N_REGS); i++) gpr[i] <= '0;
    end else begin
      done <= (state == EXEC);
      if (accept) begin
        op_q     <= b_op_in;
        cnt      <= sh_cnt;
        isl_q    <= isl;
        isr_q    <= isr;
        wr_q     <= wr;
        wr_sel_q <= wr_sel;
        adr_w_q  <= adr_w;
        if (ld_a) a_reg <= a_src ? data_in : gpr[adr_a];
        if (b_op_in == B_LOAD) begin
          b_reg <= gpr[adr_b];
        end else if (is_shift(b_op_in)) begin
          b_reg <= sh_b;
          osl   <= sh_osl;
          osr   <= sh_osr;
        end
        if (wr && !wr_sel) gpr[adr_w] <= data_in;
      end
      if (state == SHIFT) begin
        b_reg <= sh_b;
        osl   <= sh_osl;
        osr   <= sh_osr;
        cnt   <= cnt - SW'(1);
      end
      if (state == EXEC) begin
        flags[FLAG_N] <= r[WIDTH-1];
        flags[FLAG_Z] <= (r == '0);
        flags[FLAG_V] <= m ? 1'b0 : ovf;
        flags[FLAG_C] <= m ? 1'b0 : p_out;
        if (wr_q && wr_sel_q) gpr[adr_w_q] <= r;
      end
    end
  end

endmodule

// File: tb/tb_ralu_param.sv
// Randomised bench for ralu_param (WIDTH=8, N_REGS=8) with a transaction-level
// reference model compared every cycle, plus hand-computed directed checks.
module tb_ralu_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [3:0] s;
  logic       m, p_in, op_valid, op_ready, ld_a, a_src;
  logic [2:0] b_op, sh_cnt;
  logic       isl, isr, wr, wr_sel;
  logic [2:0] adr_a, adr_b, adr_w;
  logic [7:0] r;
  logic       p_out, osl, osr, done;
  logic [3:0] flags;

  always #5 clock = ~clock;

  ralu_param #(.WIDTH(8), .N_REGS(8)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .s(s), .m(m), .p_in(p_in),
    .op_valid(op_valid), .op_ready(op_ready), .ld_a(ld_a), .a_src(a_src),
    .b_op(b_op), .sh_cnt(sh_cnt), .isl(isl), .isr(isr), .wr(wr), .wr_sel(wr_sel),
    .adr_a(adr_a), .adr_b(adr_b), .adr_w(adr_w), .r(r), .p_out(p_out),
    .osl(osl), .osr(osr), .flags(flags), .done(done)
  );

  typedef struct packed {
    logic       ld_a;
    logic       a_src;
    logic [2:0] b_op;
    logic [2:0] sh_cnt;
    logic       isl;
    logic       isr;
    logic       wr;
    logic       wr_sel;
    logic [2:0] adr_a;
    logic [2:0] adr_b;
    logic [2:0] adr_w;
    logic [7:0] data;
    logic [3:0] s;
    logic       m;
    logic       p_in;
  } op_t;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ma, mb;
  logic [7:0] mg [8];
  logic       mosl, mosr, mdone, mbusy;
  logic [3:0] mflags;
  logic [2:0] qop, qadrw;
  logic [7:0] qb0;
  logic       qisl, qisr, qwr, qwsel;
  int         qk, qj;

  // Arithmetic mode is "op1 plus op2 plus carry" from the function table.
  function automatic void alu_model(input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] sel, input logic lm, input logic cin,
                                    output logic [7:0] res, output logic co, output logic ov);
    logic [7:0] x, y;
    int sum, sx, sy;
    case (sel)
      4'd0:  begin x = a;       y = 8'h00;  end
      4'd1:  begin x = a | b;   y = 8'h00;  end
      4'd2:  begin x = a | ~b;  y = 8'h00;  end
      4'd3:  begin x = 8'hFF;   y = 8'h00;  end
      4'd4:  begin x = a;       y = a & ~b; end
      4'd5:  begin x = a | b;   y = a & ~b; end
      4'd6:  begin x = a;       y = ~b;     end
      4'd7:  begin x = a & ~b;  y = 8'hFF;  end
      4'd8:  begin x = a;       y = a & b;  end
      4'd9:  begin x = a;       y = b;      end
      4'd10: begin x = a | ~b;  y = a & b;  end
      4'd11: begin x = a & b;   y = 8'hFF;  end
      4'd12: begin x = a;       y = a;      end
      4'd13: begin x = a | b;   y = a;      end
      4'd14: begin x = a | ~b;  y = a;      end
      default: begin x = a;     y = 8'hFF;  end
    endcase
    sum = int'(x) + int'(y) + int'(cin);
    sx  = x[7] ? int'(x) - 256 : int'(x);
    sy  = y[7] ? int'(y) - 256 : int'(y);
    co  = (sum >= 256);
    ov  = (sx + sy + int'(cin) > 127) || (sx + sy + int'(cin) < -128);
    if (!lm) res = 8'(sum);
    else begin
      case (sel)
        4'd0:  res = ~a;
        4'd1:  res = ~(a | b);
        4'd2:  res = ~a & b;
        4'd3:  res = 8'h00;
        4'd4:  res = ~(a & b);
        4'd5:  res = ~b;
        4'd6:  res = a ^ b;
        4'd7:  res = a & ~b;
        4'd8:  res = ~a | b;
        4'd9:  res = ~(a ^ b);
        4'd10: res = b;
        4'd11: res = a & b;
        4'd12: res = 8'hFF;
        4'd13: res = a | ~b;
        4'd14: res = a | b;
        default: res = a;
      endcase
    end
  endfunction

  // Value of B after j total shift steps from the start value b0.
  task automatic shift_model(input logic [2:0] op, input logic [7:0] b0, input int j,
                             input logic il, input logic ir,
                             inout logic [7:0] nb, inout logic ol, inout logic orr);
    case (op)
      3'd1: begin nb = (b0 << j) | (il ? ((1 << j) - 1) : 0);      ol  = b0[8-j]; end
      3'd2: begin nb = (b0 >> j) | (ir ? (8'hFF << (8 - j)) : 0); orr = b0[j-1]; end
      3'd3: begin nb = (b0 << j) | (b0 >> (8 - j));                ol  = b0[8-j]; end
      3'd4: begin nb = (b0 >> j) | (b0 << (8 - j));                orr = b0[j-1]; end
      3'd5: begin nb = $signed(b0) >>> j;                          orr = b0[j-1]; end
      default: ;
    endcase
  endtask

  task automatic model_step();
    logic [7:0] rr, ra, rb;
    logic co, ov, dn;
    dn = 1'b0;
    if (!mbusy) begin
      if (op_valid) begin
        qop = b_op; qisl = isl; qisr = isr; qwr = wr; qwsel = wr_sel; qadrw = adr_w;
        ra = mg[adr_a];
        rb = mg[adr_b];
        if (ld_a) ma = a_src ? data_in : ra;
        qk  = (b_op >= 3'd1 && b_op <= 3'd5) ? int'(sh_cnt) + 1 : 0;
        qj  = 0;
        qb0 = mb;
        if (b_op == 3'd6) mb = rb;
        else if (qk > 0) begin
          qj = 1;
          shift_model(qop, qb0, 1, qisl, qisr, mb, mosl, mosr);
        end
        if (wr && !wr_sel) mg[adr_w] = data_in;
        mbusy = 1'b1;
      end
    end else if (qj < qk) begin
      qj++;
      shift_model(qop, qb0, qj, qisl, qisr, mb, mosl, mosr);
    end else begin
      alu_model(ma, mb, s, m, p_in, rr, co, ov);
      mflags = {rr[7], rr == 8'h00, m ? 1'b0 : ov, m ? 1'b0 : co};
      if (qwr && qwsel) mg[qadrw] = rr;
      mbusy = 1'b0;
      dn = 1'b1;
    end
    mdone = dn;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        ma = '0; mb = '0; mosl = 0; mosr = 0; mflags = '0; mdone = 0; mbusy = 0;
        qk = 0; qj = 0;
        for (int i = 0; i < 8; i++) mg[i] = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic [7:0] er;
    logic eco, eov;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        alu_model(ma, mb, s, m, p_in, er, eco, eov);
        chk("op_ready", op_ready, !mbusy);
        chk("done", done, mdone);
        chk("osl", osl, mosl);
        chk("osr", osr, mosr);
        chk("flags", flags, mflags);
        chk("r", r, er);
        chk("p_out", p_out, eco);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_op(input op_t o);
    ld_a = o.ld_a; a_src = o.a_src; b_op = o.b_op; sh_cnt = o.sh_cnt;
    isl = o.isl; isr = o.isr; wr = o.wr; wr_sel = o.wr_sel;
    adr_a = o.adr_a; adr_b = o.adr_b; adr_w = o.adr_w; data_in = o.data;
    s = o.s; m = o.m; p_in = o.p_in;
  endtask

  // Returns at the falling edge of the done cycle; lat counts edges from accept.
  task automatic run_op(input op_t o, output int lat);
    logic ok;
    @(posedge clock); #1;
    set_op(o);
    op_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (op_ready) begin ok = 1'b1; break; end
    end
    chk("accept_wait", ok, 1'b1);
    @(posedge clock); #1;
    op_valid = 1'b0;
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
      lat++;
    end
    chk("done_wait", ok, 1'b1);
  endtask

  function automatic op_t wr_op(input logic [2:0] adr, input logic [7:0] d);
    op_t o = '0;
    o.wr = 1'b1; o.adr_w = adr; o.data = d;
    return o;
  endfunction

  initial begin
    op_t o;
    int lat;
    logic [6:0] rdy_seq, dn_seq;
    reset = 1'b1;
    set_op('0);
    op_valid = 1'b0;
    #12 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_r", r, 8'h00);

    // GPR write then read back through A with PASS_A
    run_op(wr_op(3'd5, 8'h3C), lat);
    o = '0; o.ld_a = 1; o.adr_a = 3'd5; o.s = 4'hF; o.m = 1;
    run_op(o, lat);
    chk("pass_a_r", r, 8'h3C);
    chk("pass_a_flags", flags, 4'b0000);

    // SHL 3 bits and SAR 1 bit from 0x81, observed via r = B
    run_op(wr_op(3'd1, 8'h81), lat);
    o = '0; o.b_op = 3'd6; o.adr_b = 3'd1; o.s = 4'hA; o.m = 1;
    run_op(o, lat);
    chk("load_b", r, 8'h81);
    o.b_op = 3'd1; o.sh_cnt = 3'd2; o.isl = 1;
    run_op(o, lat);
    chk("shl_r", r, 8'h0F);
    chk("shl_osl", osl, 1'b0);
    chk("shl_lat", lat, 4);
    o = '0; o.b_op = 3'd6; o.adr_b = 3'd1; o.s = 4'hA; o.m = 1;
    run_op(o, lat);
    o.b_op = 3'd5; o.sh_cnt = 3'd0;
    run_op(o, lat);
    chk("sar_r", r, 8'hC0);
    chk("sar_osr", osr, 1'b1);
    chk("sar_lat", lat, 2);

    // FF + 01 with write-back of r into GPR[2]
    run_op(wr_op(3'd1, 8'h01), lat);
    run_op(wr_op(3'd2, 8'h55), lat);
    o = '0; o.ld_a = 1; o.a_src = 1; o.data = 8'hFF; o.b_op = 3'd6; o.adr_b = 3'd1;
    o.s = 4'h9; o.wr = 1; o.wr_sel = 1; o.adr_w = 3'd2;
    run_op(o, lat);
    chk("add_carry_flags", flags, 4'b0101);
    chk("add_lat", lat, 2);
    o = '0; o.ld_a = 1; o.adr_a = 3'd2; o.s = 4'hF; o.m = 1;
    run_op(o, lat);
    chk("wb_gpr2", r, 8'h00);

    // 7F + 01 signed overflow
    o = '0; o.ld_a = 1; o.a_src = 1; o.data = 8'h7F; o.b_op = 3'd6; o.adr_b = 3'd1; o.s = 4'h9;
    run_op(o, lat);
    chk("add_ovf_r", r, 8'h80);
    chk("add_ovf_flags", flags, 4'b1010);

    // Reset in the middle of a 6-bit shift clears everything
    for (int i = 0; i < 8; i++) run_op(wr_op(3'(i), 8'($urandom_range(1, 255))), lat);
    @(posedge clock); #1;
    o = '0; o.b_op = 3'd1; o.sh_cnt = 3'd5; o.isl = 1; o.wr = 1; o.adr_w = 3'd6;
    o.data = 8'hA5; o.s = 4'h9;
    set_op(o);
    op_valid = 1'b1;
    @(posedge clock); #1;
    op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    chk("midrst_ready", op_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_flags", flags, 4'h0);
    chk("midrst_r", r, 8'h00);
    chk("midrst_osl", osl, 1'b0);
    @(negedge clock);
    chk("midrst_nodone", done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      o = '0; o.ld_a = 1; o.adr_a = 3'(i); o.b_op = 3'd6; o.adr_b = 3'(i); o.s = 4'hE; o.m = 1;
      run_op(o, lat);
      chk("midrst_gpr", r, 8'h00);
    end

    // Back-to-back: op_valid held high over three ops
    @(posedge clock); #1;
    o = '0; o.ld_a = 1; o.a_src = 1; o.data = 8'h11; o.b_op = 3'd6; o.adr_b = 3'd3;
    o.s = 4'h9; o.wr = 1; o.wr_sel = 1; o.adr_w = 3'd3;
    set_op(o);
    op_valid = 1'b1;
    rdy_seq = '0;
    dn_seq = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      rdy_seq = {rdy_seq[5:0], op_ready};
      dn_seq  = {dn_seq[5:0], done};
      if (i == 4) begin
        @(posedge clock); #1;
        op_valid = 1'b0;
      end
    end
    chk("b2b_ready_seq", rdy_seq, 7'b1010101);
    chk("b2b_done_seq", dn_seq, 7'b0010101);

    // Random micro-ops checked cycle-by-cycle against the model
    for (int n = 0; n < 250; n++) begin
      o.ld_a = 1'($urandom());   o.a_src = 1'($urandom());
      o.b_op = 3'($urandom());   o.sh_cnt = 3'($urandom());
      o.isl = 1'($urandom());    o.isr = 1'($urandom());
      o.wr = 1'($urandom());     o.wr_sel = 1'($urandom());
      o.adr_a = 3'($urandom());  o.adr_b = 3'($urandom()); o.adr_w = 3'($urandom());
      o.data = 8'($urandom());   o.s = 4'($urandom());
      o.m = 1'($urandom());      o.p_in = 1'($urandom());
      run_op(o, lat);
      chk("rand_lat", lat, (o.b_op >= 3'd1 && o.b_op <= 3'd5) ? int'(o.sh_cnt) + 2 : 2);
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
